// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the shared-counter scheduler.
package cnt_sched_pkg;

  localparam int DEF_NREQ = 8;
  localparam int DEF_MOD  = 25;
  localparam int DEF_CW   = 5;

  // Index width, never below one bit so a single-requester build still has a port.
  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDW = idw_of(DEF_NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first requester above last_id, wrapping around.
module rr_pick
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idw_of(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_id,
  output logic [IW-1:0]   win_id,
  output logic            win_vld
);

  int idx;

  // Scan from farthest to nearest so the nearest requester after last_id wins.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_id) + k) % NREQ;
      if (req[idx]) begin
        win_id  = IW'(idx);
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_share_sched.sv
// Shared mod-MOD counter handed out to one requester at a time, round-robin.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate on any request, grant loads length and clears count
// RUN   | owner holds the counter; one increment per cycle until length used up
// FIN   | wrap-up cycle; next edge drops grant and pulses done or abort
module cnt_share_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int MOD  = DEF_MOD,
  parameter int CW   = DEF_CW,
  localparam int IW  = idw_of(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] req_len,
  output logic [NREQ-1:0]  gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             busy,
  output logic [CW-1:0]    cnt_out,
  output logic [NREQ-1:0]  done,
  output logic             abort
);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [IW-1:0]   last_q, last_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            abort_q, abort_d;
  logic            abt_q, abt_d;

  logic [IW-1:0]   pick_id;
  logic            pick_vld;
  logic [CW-1:0]   len_sel;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .last_id (last_q),
    .win_id  (pick_id),
    .win_vld (pick_vld)
  );

  // Length is only looked at for the winner, on the grant edge.
  assign len_sel = req_len[int'(pick_id)*CW +: CW];

  // Next-state and next-output decode; every output is registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = '0;
    abort_d  = 1'b0;
    abt_d    = abt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
          gnt_id_d       = pick_id;
          busy_d         = 1'b1;
          cnt_d          = '0;
          rem_d          = len_sel;
          abt_d          = 1'b0;
          state_d        = (len_sel != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        // A dropped request wins over a normal finish and freezes the count.
        if (!req[gnt_id_q]) begin
          abt_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = (cnt_q == CW'(MOD - 1)) ? '0 : cnt_q + CW'(1);
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = gnt_id_q;
        state_d = ST_IDLE;
        if (abt_q) begin
          abort_d = 1'b1;
        end else begin
          done_d = gnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= IW'(NREQ - 1);
      busy_q   <= 1'b0;
      done_q   <= '0;
      abort_q  <= 1'b0;
      abt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      abt_q    <= abt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign cnt_out = cnt_q;
  assign done    = done_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_cnt_share_sched.sv
// Bench for the shared-counter scheduler: directed table, corner sequences, random run.
module tb_cnt_share_sched;

  localparam int NREQ = 8;
  localparam int MOD  = 25;
  localparam int CW   = 5;
  localparam int IW   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*CW-1:0] req_len = '0;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_id;
  logic              busy;
  logic [CW-1:0]     cnt_out;
  logic [NREQ-1:0]   done;
  logic              abort;

  int checks = 0;
  int failures = 0;

  cnt_share_sched #(.NREQ(NREQ), .MOD(MOD), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .cnt_out (cnt_out),
    .done    (done),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;
    int abort_at;
    int exp_gcyc;
    int exp_cnt;
    bit exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int l);
    req_len[i*CW +: CW] = CW'(l);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},    64'(gnt), 64'(0));
    chk({tag, "_busy"},   64'(busy), 64'(0));
    chk({tag, "_cnt"},    64'(cnt_out), 64'(0));
    chk({tag, "_gnt_id"}, 64'(gnt_id), 64'(0));
    chk({tag, "_done"},   64'(done), 64'(0));
    chk({tag, "_abort"},  64'(abort), 64'(0));
  endtask

  // One isolated request: walk its grant window, then check the wrap-up pulse.
  task automatic run_vec(input vec_t v);
    int k;
    int ecnt;
    set_len(v.id, v.len);
    req[v.id] = 1'b1;
    tick();
    chk("vec_gnt_id", 64'(gnt_id), 64'(v.id));
    k = 0;
    while (gnt != '0 && k < 100) begin
      ecnt = (v.abort_at >= 0 && k > v.abort_at) ? (v.abort_at % MOD) : (k % MOD);
      chk("vec_gnt", 64'(gnt), 64'(1) << v.id);
      chk("vec_cnt", 64'(cnt_out), 64'(ecnt));
      chk("vec_busy", 64'(busy), 64'(1));
      if (k == v.abort_at) req[v.id] = 1'b0;
      if (k == 1) set_len(v.id, 31 - v.len);
      tick();
      k++;
    end
    chk("vec_gcyc", 64'(k), 64'(v.exp_gcyc));
    chk("vec_cnt_end", 64'(cnt_out), 64'(v.exp_cnt));
    chk("vec_done", 64'(done), v.exp_done ? (64'(1) << v.id) : 64'(0));
    chk("vec_abort", 64'(abort), 64'(!v.exp_done));
    chk("vec_busy_end", 64'(busy), 64'(0));
    req[v.id] = 1'b0;
    tick();
    chk("vec_done_clr", 64'(done), 64'(0));
    chk("vec_abort_clr", 64'(abort), 64'(0));
    chk("vec_cnt_hold", 64'(cnt_out), 64'(v.exp_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int last_m, cnt_m, w, l, a, exp_g, ecnt, j;

    vecs[0] = '{id: 2, len: 3,  abort_at: -1, exp_gcyc: 4,  exp_cnt: 3, exp_done: 1'b1};
    vecs[1] = '{id: 5, len: 30, abort_at: -1, exp_gcyc: 31, exp_cnt: 5, exp_done: 1'b1};
    vecs[2] = '{id: 1, len: 10, abort_at: 4,  exp_gcyc: 6,  exp_cnt: 4, exp_done: 1'b0};
    vecs[3] = '{id: 3, len: 0,  abort_at: -1, exp_gcyc: 1,  exp_cnt: 0, exp_done: 1'b1};
    vecs[4] = '{id: 6, len: 25, abort_at: -1, exp_gcyc: 26, exp_cnt: 0, exp_done: 1'b1};
    vecs[5] = '{id: 4, len: 1,  abort_at: 0,  exp_gcyc: 2,  exp_cnt: 0, exp_done: 1'b0};
    vecs[6] = '{id: 7, len: 5,  abort_at: 4,  exp_gcyc: 6,  exp_cnt: 4, exp_done: 1'b0};

    #12;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk("idle_gnt", 64'(gnt), 64'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // All requesters held high with unit length: strict rotation 0..7 then 0.
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = '1;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk("rr_gnt", 64'(gnt), 64'(1) << (g % NREQ));
      chk("rr_gnt_id", 64'(gnt_id), 64'(g % NREQ));
      tick();
      chk("rr_gnt_fin", 64'(gnt), 64'(1) << (g % NREQ));
      tick();
      chk("rr_gap_gnt", 64'(gnt), 64'(0));
      chk("rr_done", 64'(done), 64'(1) << (g % NREQ));
      if (g == 8) req = '0;
    end
    tick();

    // Reset in the middle of a run, then requester 0 must win against 4.
    set_len(4, 20);
    set_len(0, 2);
    req = 8'h10;
    tick();
    tick();
    tick();
    tick();
    chk("mid_cnt", 64'(cnt_out), 64'(3));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    req = 8'h11;
    tick();
    chk("midrst_done_hold", 64'(done), 64'(0));
    chk("midrst_abort_hold", 64'(abort), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 64'(gnt), 64'(1));
    chk("post_rst_gnt_id", 64'(gnt_id), 64'(0));

    // Random traffic against a transaction-level model.
    req = '0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    last_m = NREQ - 1;
    cnt_m  = 0;
    for (int t = 0; t < 80; t++) begin
      if (t % 7 != 3) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i] && $urandom_range(0, 2) == 0) begin
            set_len(i, int'($urandom_range(0, 31)));
            req[i] = 1'b1;
          end
        end
      end
      if (req == '0) begin
        tick();
        chk("rnd_idle_gnt", 64'(gnt), 64'(0));
        chk("rnd_idle_busy", 64'(busy), 64'(0));
        chk("rnd_idle_cnt", 64'(cnt_out), 64'(cnt_m));
        continue;
      end
      w = -1;
      for (int s = 1; s <= NREQ; s++) begin
        if (w < 0 && req[(last_m + s) % NREQ]) w = (last_m + s) % NREQ;
      end
      l = int'(req_len[w*CW +: CW]);
      a = (l > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, l - 1)) : -1;
      exp_g = (a >= 0) ? a + 2 : ((l == 0) ? 1 : l + 1);
      tick();
      chk("rnd_gnt_id", 64'(gnt_id), 64'(w));
      for (int k = 0; k < exp_g; k++) begin
        ecnt = (a >= 0 && k > a) ? (a % MOD) : (k % MOD);
        chk("rnd_gnt", 64'(gnt), 64'(1) << w);
        chk("rnd_cnt", 64'(cnt_out), 64'(ecnt));
        chk("rnd_busy", 64'(busy), 64'(1));
        chk("rnd_nopulse", 64'({done, abort}), 64'(0));
        if (k == a) req[w] = 1'b0;
        if (k == 0) set_len(w, int'($urandom_range(0, 31)));
        j = int'($urandom_range(0, NREQ - 1));
        if (j != w && !req[j] && $urandom_range(0, 2) == 0) begin
          set_len(j, int'($urandom_range(0, 31)));
          req[j] = 1'b1;
        end
        tick();
      end
      cnt_m = (a >= 0) ? (a % MOD) : (l % MOD);
      chk("rnd_end_gnt", 64'(gnt), 64'(0));
      chk("rnd_end_busy", 64'(busy), 64'(0));
      chk("rnd_end_cnt", 64'(cnt_out), 64'(cnt_m));
      chk("rnd_end_done", 64'(done), (a >= 0) ? 64'(0) : (64'(1) << w));
      chk("rnd_end_abort", 64'(abort), 64'(a >= 0));
      last_m = w;
      req[w] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_share_sched.md
CNT_SHARE_SCHED -- requirements
Module: cnt_share_sched

Interface
REQ-001 Parameter NREQ, default 8: number of requesters sharing the counter.
REQ-002 Parameter MOD, default 25: counter modulus; count sequence is 0..MOD-1.
REQ-003 Parameter CW, default 5: counter and length width in bits.
REQ-004 Port clk, input, 1: single clock; all state changes on posedge clk.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port req, input, NREQ: level request per requester; must stay high until done or abort.
REQ-007 Port req_len, input, NREQ*CW: requested tick count per requester; slice i is bits [i*CW +: CW].
REQ-008 Port gnt, output, NREQ: one-hot grant; all-zero when no owner.
REQ-009 Port gnt_id, output, clog2(NREQ): binary index of the current or last owner.
REQ-010 Port busy, output, 1: high while any requester owns the counter.
REQ-011 Port cnt_out, output, CW: shared mod-MOD counter value.
REQ-012 Port done, output, NREQ: one-cycle pulse on the owner's bit when its run completes normally.
REQ-013 Port abort, output, 1: one-cycle pulse when the owner drops req mid-run.

Function
REQ-014 States: IDLE, RUN, FIN.
REQ-015 IDLE with req==0: stay in IDLE; gnt=0, busy=0, cnt_out holds.
REQ-016 IDLE with req!=0: select the winner round-robin, searching upward from last_id+1 with wrap.
REQ-017 On that edge: gnt=onehot(winner), gnt_id=winner, busy=1, cnt_out=0, rem=req_len[winner].
REQ-018 Next state is RUN if the latched length is nonzero, otherwise FIN.
REQ-019 The length is sampled only at grant; later req_len changes are ignored.
REQ-020 RUN, each cycle: cnt_out <= (cnt_out==MOD-1) ? 0 : cnt_out+1; rem <= rem-1.
REQ-021 RUN with rem==1: next state is FIN, after exactly len increments.
REQ-022 Lengths greater than MOD are legal; the counter wraps MOD-1 -> 0 and continues.
REQ-023 RUN with req[owner]==0: next state is FIN with an abort flag set.
REQ-024 On an abort: cnt_out freezes and no done is produced; abort takes priority over rem==1 on the same cycle.
REQ-025 FIN lasts one cycle and produces either done[owner]=1 or abort=1, never both.
REQ-026 In FIN: gnt=0, busy=0, last_id=owner; next state is IDLE.
REQ-027 There is no back-to-back grant; minimum gap between grants is one IDLE cycle.
REQ-028 Requests from non-owners during RUN/FIN are ignored until IDLE.
REQ-029 cnt_out holds its final value through FIN and IDLE until the next grant clears it.
REQ-030 gnt is registered and glitch-free; at most one bit is set at any time.

Reset
REQ-031 On rst_n low, asynchronously force:
- state=IDLE
- gnt=0, busy=0, done=0, abort=0
- cnt_out=0, rem=0
- gnt_id=0, last_id=NREQ-1, so requester 0 has first priority.
REQ-032 Reset mid-run discards the run with no done or abort pulse; operation resumes on the first clk after rst_n rises.

Structure
REQ-033 Package cnt_sched_pkg holds: the state enum (IDLE, RUN, FIN), default MOD, CW, NREQ, and the IDW=clog2(NREQ) constant.
REQ-034 Sub-module rr_pick is purely combinational: inputs are the request vector and last_id; outputs are the winner index and a valid flag.
REQ-035 All other logic (FSM, counter, rem) lives in cnt_share_sched.

Verification
REQ-036 req[2]=1, len=3 from reset -> gnt=0x04 for 4 cycles; cnt_out 0,1,2,3; done[2] pulses in the following cycle.
REQ-037 req=0xFF held, all len=1 -> grant order 0,1,2..7,0; each grant is separated by FIN and IDLE cycles.
REQ-038 req[5]=1, len=30 -> cnt_out runs 0..24,0..5; done[5] pulses after 30 increments.
REQ-039 req[1] dropped when cnt_out=4 -> abort pulses once; done stays 0; cnt_out stays 4; busy falls.
REQ-040 len=0 on requester 3 -> grant cycle, then FIN with done[3]=1; cnt_out=0.
REQ-041 rst_n pulled low mid-RUN -> outputs go to reset values immediately; no pulses; requester 0 wins next.
